// File: rtl/fetch_pc_unit_pkg.sv
// Common types for the fetch PC unit.
`include "opcodes.v"

package fetch_pc_unit_pkg;
    // Next-PC source, in priority order.
    typedef enum logic [1:0] {
        NPC_HOLD,
        NPC_RAS,
        NPC_TARGET,
        NPC_SEQ
    } npc_sel_e;

    localparam int DEF_PC_W      = 16;
    localparam int DEF_RAS_DEPTH = `RAS_DEPTH_DEFAULT;

    // Select the next-PC source from stall/redirect/op.
    function automatic npc_sel_e npc_select(input logic stall, input logic kill,
                                            input logic [3:0] op);
        if (stall)              return NPC_HOLD;
        else if (!kill)         return NPC_SEQ;
        else if (op == `OP_RET) return NPC_RAS;
        else                    return NPC_TARGET;
    endfunction
endpackage

// File: rtl/fetch_pc_unit_if.sv
// Decode-to-fetch redirect bus: hazard side is master, fetch unit is slave.
interface fetch_pc_unit_if #(parameter int PC_W = 16);
    logic            stall;
    logic            kill;
    logic [3:0]      op;
    logic [PC_W-1:0] pc_id;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc;
    logic            flush;

    modport master (output stall, kill, op, pc_id, target, input pc, flush);
    modport slave  (input stall, kill, op, pc_id, target, output pc, flush);
endinterface

// File: rtl/fetch_pc_unit_return_stack.sv
// Circular return-address stack with saturating count and sticky error flags.
module return_stack #(
    parameter int PC_W  = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic [CW-1:0]   count,
    output logic            overflow,
    output logic            underflow
);
    logic [PC_W-1:0] mem [DEPTH];
    logic [AW-1:0]   ptr;       // next free slot; ptr-1 is the top entry

    wire full  = (count == CW'(DEPTH));
    wire empty = (count == '0);

    assign top = mem[ptr - AW'(1)];

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) mem[ptr] <= push_data;
    end

    // Pointer, count and sticky flags. A full push overwrites the oldest
    // entry because the slot at ptr is the oldest once the ring has wrapped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (push) begin
            ptr <= ptr + AW'(1);
            if (full) overflow <= 1'b1;
            else      count    <= count + CW'(1);
        end else if (pop) begin
            if (empty) begin
                underflow <= 1'b1;
            end else begin
                ptr   <= ptr - AW'(1);
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: rtl/opcodes.v
// Shared opcode encodings and fetch-unit defaults for the 16-bit pipeline.
`ifndef OPCODES_V
`define OPCODES_V

`define OP_BEQ  4'h8
`define OP_BNE  4'h9
`define OP_JMP  4'hA
`define OP_CALL 4'hB
`define OP_RET  4'hC
`define OP_FOR  4'hD

`define RESET_PC_DEFAULT  16'h0000
`define RAS_DEPTH_DEFAULT 4

`endif

// File: rtl/fetch_pc_unit.sv
// Fetch PC register and redirect mux; owns the return-address stack.
`include "opcodes.v"

module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int              PC_W      = DEF_PC_W,
    parameter int              RAS_DEPTH = DEF_RAS_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(`RESET_PC_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fetch_pc_unit_if.slave             bus,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_overflow,
    output logic                       ras_underflow
);
    logic            redirect;
    logic            push, pop;
    logic [PC_W-1:0] ras_top;
    logic [PC_W-1:0] pc_q;
    npc_sel_e        sel;

    assign redirect  = bus.kill & ~bus.stall;
    assign bus.flush = redirect;
    assign push      = redirect & (bus.op == `OP_CALL);
    assign pop       = redirect & (bus.op == `OP_RET);
    assign sel       = npc_select(bus.stall, bus.kill, bus.op);
    assign bus.pc    = pc_q;

    return_stack #(.PC_W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (bus.pc_id + PC_W'(1)),
        .top       (ras_top),
        .count     (ras_count),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    // PC update; an empty-stack RET falls back to RESET_PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            case (sel)
                NPC_HOLD:   pc_q <= pc_q;
                NPC_RAS:    pc_q <= (ras_count == '0) ? RESET_PC : ras_top;
                NPC_TARGET: pc_q <= bus.target;
                default:    pc_q <= pc_q + PC_W'(1);
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit.
`include "opcodes.v"

module tb_fetch_pc_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] ras_count;
    logic       ras_overflow, ras_underflow;
    int total = 0;
    int bad   = 0;

    fetch_pc_unit_if #(.PC_W(16)) bus ();

    fetch_pc_unit #(.PC_W(16), .RAS_DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall = 1'b0; bus.kill = 1'b0; bus.op = 4'h0;
        bus.pc_id = 16'h0; bus.target = 16'h0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #1;
        total++; if (bus.pc !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h exp=0000", bus.pc); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", ras_count); end
        total++; if ({ras_overflow, ras_underflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {ras_overflow, ras_underflow}); end
        step(); step();
        rst_n = 1'b1;
        total++; if (bus.pc !== 16'h0000) begin bad++; $display("FAIL release_pc got=%h exp=0000", bus.pc); end
        for (int i = 1; i <= 5; i++) begin
            step();
            total++; if (bus.pc !== 16'(i)) begin bad++; $display("FAIL seq_pc%0d got=%h exp=%h", i, bus.pc, 16'(i)); end
            total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL seq_flush got=%b exp=0", bus.flush); end
        end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL seq_cnt got=%0d exp=0", ras_count); end
    endtask

    task automatic test_branch();
        step(); step(); step();
        total++; if (bus.pc !== 16'h0008) begin bad++; $display("FAIL br_start got=%h exp=0008", bus.pc); end
        bus.kill = 1'b1; bus.op = `OP_BEQ; bus.target = 16'h0040;
        #1;
        total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL br_flush got=%b exp=1", bus.flush); end
        step();
        total++; if (bus.pc !== 16'h0040) begin bad++; $display("FAIL br_tgt got=%h exp=0040", bus.pc); end
        idle();
        step();
        total++; if (bus.pc !== 16'h0041) begin bad++; $display("FAIL br_next got=%h exp=0041", bus.pc); end
    endtask

    task automatic test_stall_kill();
        bus.stall = 1'b1; bus.kill = 1'b1; bus.op = `OP_JMP; bus.target = 16'h0100;
        #1;
        total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL stall_flush got=%b exp=0", bus.flush); end
        step();
        total++; if (bus.pc !== 16'h0041) begin bad++; $display("FAIL stall_hold got=%h exp=0041", bus.pc); end
        bus.stall = 1'b0;
        #1;
        total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL unstall_flush got=%b exp=1", bus.flush); end
        step();
        total++; if (bus.pc !== 16'h0100) begin bad++; $display("FAIL unstall_pc got=%h exp=0100", bus.pc); end
        idle();
        // op alone without kill must not touch the stack
        bus.op = `OP_CALL; bus.pc_id = 16'h0123;
        step();
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL op_nokill_cnt got=%0d exp=0", ras_count); end
        idle();
    endtask

    task automatic test_call_ret();
        bus.kill = 1'b1; bus.op = `OP_CALL; bus.pc_id = 16'h0010; bus.target = 16'h0200;
        step();
        total++; if (bus.pc !== 16'h0200) begin bad++; $display("FAIL call1_pc got=%h exp=0200", bus.pc); end
        bus.pc_id = 16'h0205; bus.target = 16'h0300;
        step();
        total++; if (ras_count !== 3'd2) begin bad++; $display("FAIL call2_cnt got=%0d exp=2", ras_count); end
        bus.op = `OP_RET;
        step();
        total++; if (bus.pc !== 16'h0206) begin bad++; $display("FAIL ret1_pc got=%h exp=0206", bus.pc); end
        step();
        total++; if (bus.pc !== 16'h0011) begin bad++; $display("FAIL ret2_pc got=%h exp=0011", bus.pc); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL ret2_cnt got=%0d exp=0", ras_count); end
        idle();
    endtask

    task automatic test_overflow();
        logic [15:0] exp_ret [4];
        exp_ret[0] = 16'h6; exp_ret[1] = 16'h5; exp_ret[2] = 16'h4; exp_ret[3] = 16'h3;
        bus.kill = 1'b1; bus.op = `OP_CALL;
        for (int i = 1; i <= 5; i++) begin
            bus.pc_id = 16'(i); bus.target = 16'h0400 + 16'(i);
            step();
        end
        total++; if (ras_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", ras_overflow); end
        total++; if (ras_count !== 3'd4) begin bad++; $display("FAIL ovf_cnt got=%0d exp=4", ras_count); end
        bus.op = `OP_RET;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (bus.pc !== exp_ret[i]) begin bad++; $display("FAIL ovf_ret%0d got=%h exp=%h", i, bus.pc, exp_ret[i]); end
        end
        total++; if (ras_underflow !== 1'b0) begin bad++; $display("FAIL ovf_unf got=%b exp=0", ras_underflow); end
        idle();
    endtask

    task automatic test_underflow_wrap();
        bus.kill = 1'b1; bus.op = `OP_RET; bus.target = 16'h0777;
        step();
        total++; if (bus.pc !== 16'h0000) begin bad++; $display("FAIL unf_pc got=%h exp=0000", bus.pc); end
        total++; if (ras_underflow !== 1'b1) begin bad++; $display("FAIL unf_flag got=%b exp=1", ras_underflow); end
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL unf_cnt got=%0d exp=0", ras_count); end
        bus.op = `OP_JMP; bus.target = 16'hFFFF;
        step();
        idle();
        step();
        total++; if (bus.pc !== 16'h0000) begin bad++; $display("FAIL wrap_pc got=%h exp=0000", bus.pc); end
        // unlisted opcode with kill behaves as a target redirect
        bus.kill = 1'b1; bus.op = 4'h3; bus.target = 16'h0055;
        step();
        total++; if (bus.pc !== 16'h0055) begin bad++; $display("FAIL other_op got=%h exp=0055", bus.pc); end
        idle();
    endtask

    task automatic test_reset_mid_redirect();
        bus.kill = 1'b1; bus.op = `OP_CALL; bus.pc_id = 16'h0030; bus.target = 16'h0500;
        rst_n = 1'b0;
        step();
        total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d exp=0", ras_count); end
        total++; if (bus.pc !== 16'h0000) begin bad++; $display("FAIL rstmid_pc got=%h exp=0000", bus.pc); end
        total++; if ({ras_overflow, ras_underflow} !== 2'b00) begin bad++; $display("FAIL rstmid_flags got=%b exp=00", {ras_overflow, ras_underflow}); end
        idle();
        rst_n = 1'b1;
        step();
        total++; if (bus.pc !== 16'h0001) begin bad++; $display("FAIL rstmid_rel got=%h exp=0001", bus.pc); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall_kill();
        test_call_ret();
        test_overflow();
        test_underflow_wrap();
        test_reset_mid_redirect();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Fetch-stage program-counter and redirect unit for the 16-bit pipelined processor. It consumes the decode-stage `kill` decision and the resolved branch/jump target, steers the fetch PC, flushes the IF/ID register, and owns the hardware return-address stack that backs `CALL`/`RET`. It is the receiving end of the control-hazard decision: the hazard logic decides whether to redirect, and this block performs the redirect.

## Interface
Parameters:
- `PC_W`, 16: PC and target width.
- `RAS_DEPTH`, 4: return-stack entries; must be a power of two, at least 2.
- `RESET_PC`, 16'h0000: PC value after reset.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  data-hazard stall; hold PC and IF/ID.
- `kill`  in  1  redirect request for the instruction in decode.
- `op`  in  4  opcode of the instruction in decode (`opcodes.v` encodings).
- `pc_id`  in  PC_W  PC of the instruction in decode.
- `target`  in  PC_W  resolved target for BEQ/BNE/JMP/CALL/FOR.
- `pc`  out  PC_W  current fetch address.
- `flush`  out  1  combinational; squash the IF/ID entry at the next edge.
- `ras_count`  out  $clog2(RAS_DEPTH)+1  live return-stack entries.
- `ras_overflow`  out  1  sticky; a push occurred while the stack was full.
- `ras_underflow`  out  1  sticky; a pop occurred while the stack was empty.

## Operation
- Define `redirect = kill & ~stall`. `flush = redirect`.
- Next-PC priority, applied at each rising edge:
  1. `stall`: `pc` holds. No push or pop, even if `kill=1`.
  2. `redirect` with `op==RET`: `pc <= ` top of stack, then pop.
  3. `redirect` with any other op: `pc <= target`.
  4. Otherwise: `pc <= pc + 1`, wrapping modulo 2^PC_W (16'hFFFF becomes 16'h0000).
- Stack push: on `redirect & op==CALL`, push `pc_id + 1` (mod 2^PC_W).
- Stack pop: on `redirect & op==RET`.
- A push or pop only happens when `redirect` is set; `op` alone never touches the stack.
- Full push: the stack is circular. The oldest entry is overwritten, `ras_count` stays at RAS_DEPTH, and `ras_overflow` sets.
- Empty pop: `pc <= RESET_PC`, `ras_count` stays 0, and `ras_underflow` sets.
- Sticky flags clear only on reset.
- `kill` with an op outside {BEQ, BNE, JMP, CALL, RET, FOR} is treated as case 3.

## Timing
- Reset values (asynchronous, immediate on `rst_n=0`):
  - `pc = RESET_PC`
  - `ras_count = 0`
  - both sticky flags 0
  - stack pointer 0; entry contents don't-care.
- `flush` follows `kill` and `stall` combinationally and is 0 whenever `stall=1`.
- Redirect latency: one edge. The cycle `redirect=1` is sampled, `pc` shows the target in the next cycle, and exactly one wrong-path instruction (the one in IF) is squashed.
- The RET read of the top entry is combinational from stack state. A CALL immediately followed by a RET in the next decode cycle returns the just-pushed value.
- Reset asserted mid-redirect wins: no push or pop is committed.
- Removing reset is synchronous to `clk`. The first edge after release fetches from RESET_PC+1 unless a redirect occurs.

## Structure
- Opcode defines (BEQ, BNE, JMP, CALL, RET, FOR) come from the shared `opcodes.v` header. Do not re-declare them locally.
- RESET_PC default and RAS_DEPTH default go in the same shared header as constants.
- One sub-module, `return_stack`. It holds the circular storage, pointer, count and sticky flags, with `push`, `pop`, `push_data`, `top`, `count`, `overflow` and `underflow` ports.
- The top level holds the PC register and next-PC mux.

## Test plan
- **Reset and sequential fetch:** reset, release, 5 idle cycles → `pc` = 0,1,2,3,4,5; `flush=0`; `ras_count=0`.
- **Branch taken:** at `pc`=8, drive `kill=1`, `op=BEQ`, `target`=16'h0040 for one cycle → `flush=1` that cycle; `pc`=16'h0040 next cycle, then 16'h0041.
- **Stall masks kill:** `stall=1` and `kill=1` (`op=JMP`, `target`=16'h0100) together → `flush=0`, `pc` unchanged. Drop `stall` with `kill` still 1 → `pc`=16'h0100 on the next edge.
- **CALL/RET nesting:** CALL at `pc_id`=16'h0010 (`target` 16'h0200), then CALL at `pc_id`=16'h0205 (`target` 16'h0300) → `ras_count`=2. RET → `pc`=16'h0206. Second RET → `pc`=16'h0011; `ras_count`=0.
- **Overflow:** 5 CALLs with RAS_DEPTH=4 and `pc_id`=1..5 → `ras_overflow=1`, `ras_count`=4. Four RETs return 6,5,4,3.
- **Underflow and wrap:** RET on an empty stack → `pc`=RESET_PC and `ras_underflow=1`. Separately, free-run from `pc`=16'hFFFF → `pc`=16'h0000.
